icnd2110_out: RTL and testbench
===============================

ICND2110_OUT -- requirements
Module: icnd2110_out

Interface
REQ-001 SHALL have parameter ADDRESS_BUS_WIDTH, default 16: width of word_count, start_address and read_address.
REQ-002 SHALL have parameter CLOCK_HALF_PERIOD, default 2: clk cycles per clock_out half-period.
REQ-003 SHALL have parameter FRAME_GAP_CYCLES, default 256: idle clk cycles between frames.
REQ-004 SHALL have port clk  input  1  the only clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset (0 = in reset).
REQ-006 SHALL have port word_count  input  ADDRESS_BUS_WIDTH  16-bit words per frame.
REQ-007 SHALL have port start_address  input  ADDRESS_BUS_WIDTH  word address of frame word 0.
REQ-008 SHALL have port read_address  output  ADDRESS_BUS_WIDTH  word address being requested.
REQ-009 SHALL have port read_request  output  1  high while a word fetch is pending.
REQ-010 SHALL have port read_data  input  16  shared RAM data, valid only while read_finished_strobe is high.
REQ-011 SHALL have port read_finished_strobe  input  1  one-cycle grant/data-valid pulse from the arbiter.
REQ-012 SHALL have port data_out  output  1  serial data to the ICND2110 chain.
REQ-013 SHALL have port clock_out  output  1  serial clock to the ICND2110 chain.

Function
REQ-014 SHALL be a registered FSM with states REQUEST, SHIFT and GAP; all outputs SHALL be registered.
REQ-015 On frame start, SHALL latch word_count and start_address and clear word index to 0; input changes mid-frame SHALL NOT affect the current frame.
REQ-016 If the latched word_count is 0, SHALL go directly to GAP with no reads and no clocks.
REQ-017 In REQUEST, SHALL drive read_request=1 and read_address=(start_address+index) mod 2^ADDRESS_BUS_WIDTH, with wrap-around.
REQ-018 SHALL hold read_request and read_address stable until read_finished_strobe=1.
REQ-019 On that strobe cycle, SHALL capture read_data into a 16-bit shift register and enter SHIFT.
REQ-020 read_request SHALL be 0 from the next cycle on.
REQ-021 read_finished_strobe outside REQUEST SHALL be ignored.
REQ-022 In SHIFT, SHALL emit 16 bits MSB first; each bit lasts 2*CLOCK_HALF_PERIOD cycles.
REQ-023 For each bit, data_out SHALL change at the start of the bit while clock_out=0, hold for CLOCK_HALF_PERIOD cycles, then clock_out=1 for CLOCK_HALF_PERIOD cycles; data SHALL be stable across the rising edge.
REQ-024 After bit 0, clock_out and data_out SHALL return to 0; index SHALL increment.
REQ-025 If index < word_count after the increment, SHALL return to REQUEST; otherwise SHALL enter GAP.
REQ-026 In GAP, clock_out=0, data_out=0 and read_request=0 SHALL hold for exactly FRAME_GAP_CYCLES cycles, then a new frame SHALL start (REQ-015).
REQ-027 Frames SHALL repeat indefinitely while rst=1.
REQ-028 Index arithmetic SHALL be ADDRESS_BUS_WIDTH wide; word_count=0xFFFF SHALL yield 65535 words.

Reset
REQ-029 While rst=0, data_out=0, clock_out=0, read_request=0, read_address=0, index=0, shift register=0 and the FSM SHALL be in GAP with the counter cleared.
REQ-030 rst falling mid-word or mid-request SHALL abort immediately, with no completion of the partial word.
REQ-031 On the first clk edge after rst rises, SHALL start a frame (REQUEST, or GAP if word_count=0) without waiting FRAME_GAP_CYCLES.

Verification
REQ-032 word_count=1, start_address=0x0100, strobe 3 cycles after request with read_data=0xA5C3 -> read_address=0x0100 and exactly 16 clock_out rising edges sampling 1010010111000011.
REQ-033 word_count=3, start_address=0xFFFE -> read addresses 0xFFFE, 0xFFFF, 0x0000, then 256 idle cycles, then a repeat at 0xFFFE.
REQ-034 word_count=0 -> read_request never asserted and clock_out constantly 0 over 2000 cycles.
REQ-035 Strobe pulses while idle/shifting, with read_data=0xFFFF -> no effect on the shifted data or the state.
REQ-036 rst driven low at bit 7 of a word -> outputs 0 asynchronously; after release, the frame restarts at start_address with word 0.
REQ-037 start_address changed mid-frame -> current frame addresses unchanged; the next frame uses the new value.

Source files
------------

// File: rtl/icnd2110_out.sv
// ICND2110 serial output engine.
// Fetches 16-bit words from a shared RAM through a request/strobe handshake
// and shifts each one out MSB first on a data/clock pair, then idles for a
// fixed gap before starting the next frame. Frames repeat while out of reset.
module icnd2110_out #(
  parameter int ADDRESS_BUS_WIDTH = 16,
  parameter int CLOCK_HALF_PERIOD = 2,
  parameter int FRAME_GAP_CYCLES  = 256
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ADDRESS_BUS_WIDTH-1:0] word_count,
  input  logic [ADDRESS_BUS_WIDTH-1:0] start_address,
  output logic [ADDRESS_BUS_WIDTH-1:0] read_address,
  output logic                         read_request,
  input  logic [15:0]                  read_data,
  input  logic                         read_finished_strobe,
  output logic                         data_out,
  output logic                         clock_out
);

  localparam int PH_W  = (2 * CLOCK_HALF_PERIOD > 1) ? $clog2(2 * CLOCK_HALF_PERIOD) : 1;
  localparam int GAP_W = (FRAME_GAP_CYCLES > 1) ? $clog2(FRAME_GAP_CYCLES) : 1;

  localparam logic [PH_W-1:0]  PH_HIGH  = PH_W'(CLOCK_HALF_PERIOD - 1);
  localparam logic [PH_W-1:0]  PH_END   = PH_W'(2 * CLOCK_HALF_PERIOD - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((FRAME_GAP_CYCLES > 0) ? FRAME_GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    GAP,
    REQUEST,
    SHIFT
  } state_t;

  state_t                         r_state;
  logic [ADDRESS_BUS_WIDTH-1:0]   r_wc;
  logic [ADDRESS_BUS_WIDTH-1:0]   r_start;
  logic [ADDRESS_BUS_WIDTH-1:0]   r_index;
  logic [ADDRESS_BUS_WIDTH-1:0]   r_read_address;
  logic                           r_read_request;
  logic                           r_clock_out;
  logic [15:0]                    r_shift;
  logic [3:0]                     r_bit;
  logic [PH_W-1:0]                r_ph;
  logic [GAP_W-1:0]               r_gap_cnt;

  logic [ADDRESS_BUS_WIDTH-1:0]   w_next_index;

  assign w_next_index = r_index + ADDRESS_BUS_WIDTH'(1);

  // data_out is the MSB of the shift register itself; zeros shifted in behind
  // the last bit leave the line low after each word without an extra flop.
  assign data_out     = r_shift[15];
  assign clock_out    = r_clock_out;
  assign read_request = r_read_request;
  assign read_address = r_read_address;

  // Frame sequencer: gap timing, word fetch handshake and bit serialisation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= GAP;
      r_wc           <= '0;
      r_start        <= '0;
      r_index        <= '0;
      r_read_address <= '0;
      r_read_request <= 1'b0;
      r_clock_out    <= 1'b0;
      r_shift        <= '0;
      r_bit          <= '0;
      r_ph           <= '0;
      r_gap_cnt      <= '0;
    end else begin
      case (r_state)
        GAP: begin
          r_clock_out    <= 1'b0;
          r_read_request <= 1'b0;
          // A cleared counter means the gap is over (or reset just released).
          if (r_gap_cnt == '0) begin
            r_wc    <= word_count;
            r_start <= start_address;
            r_index <= '0;
            if (word_count == '0) begin
              r_state   <= GAP;
              r_gap_cnt <= GAP_LOAD;
            end else begin
              r_state        <= REQUEST;
              r_read_request <= 1'b1;
              r_read_address <= start_address;
            end
          end else begin
            r_gap_cnt <= r_gap_cnt - GAP_W'(1);
          end
        end

        REQUEST: begin
          if (read_finished_strobe) begin
            r_shift        <= read_data;
            r_read_request <= 1'b0;
            r_clock_out    <= 1'b0;
            r_bit          <= 4'd15;
            r_ph           <= '0;
            r_state        <= SHIFT;
          end
        end

        SHIFT: begin
          if (r_ph == PH_END) begin
            r_ph        <= '0;
            r_clock_out <= 1'b0;
            r_shift     <= {r_shift[14:0], 1'b0};
            if (r_bit == 4'd0) begin
              r_index <= w_next_index;
              if (w_next_index < r_wc) begin
                r_state        <= REQUEST;
                r_read_request <= 1'b1;
                r_read_address <= r_start + w_next_index;
              end else begin
                r_state   <= GAP;
                r_gap_cnt <= GAP_LOAD;
              end
            end else begin
              r_bit <= r_bit - 4'd1;
            end
          end else begin
            if (r_ph == PH_HIGH) begin
              r_clock_out <= 1'b1;
            end
            r_ph <= r_ph + PH_W'(1);
          end
        end

        default: begin
          r_state <= GAP;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icnd2110_out.sv
// Directed/randomized bench for icnd2110_out: acts as the RAM arbiter and
// decodes the serial stream, comparing against addresses and words the
// bench itself chose.
module tb_icnd2110_out;

  localparam int AW  = 16;
  localparam int HP  = 2;
  localparam int GAP = 256;

  logic          clk;
  logic          rst;
  logic [AW-1:0] word_count;
  logic [AW-1:0] start_address;
  logic [AW-1:0] read_address;
  logic          read_request;
  logic [15:0]   read_data;
  logic          read_finished_strobe;
  logic          data_out;
  logic          clock_out;

  int total = 0;
  int bad   = 0;

  icnd2110_out #(
    .ADDRESS_BUS_WIDTH (AW),
    .CLOCK_HALF_PERIOD (HP),
    .FRAME_GAP_CYCLES  (GAP)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .word_count           (word_count),
    .start_address        (start_address),
    .read_address         (read_address),
    .read_request         (read_request),
    .read_data            (read_data),
    .read_finished_strobe (read_finished_strobe),
    .data_out             (data_out),
    .clock_out            (clock_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Wait for a request, check address/hold, grant it, then decode 16 bits.
  task automatic serve_word(input logic [AW-1:0] exp_addr, input int dly,
                            input logic [15:0] d, input bit noise);
    int n;
    int rises;
    int n_first;
    int n_last;
    bit ok;
    bit stable;
    bit reqok;
    logic [15:0] got;
    logic prev_clk;
    logic prev_dat;
    n = 0;
    while (read_request !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("req_seen", read_request, 1);
    chk("req_addr", read_address, exp_addr);
    ok = 1;
    repeat (dly) begin
      @(negedge clk);
      if (read_request !== 1'b1 || read_address !== exp_addr) ok = 0;
    end
    chk("req_hold", ok, 1);
    read_finished_strobe = 1'b1;
    read_data = d;
    @(negedge clk);
    read_finished_strobe = 1'b0;
    read_data = 16'($urandom);
    chk("req_drop", read_request, 0);
    n = 0; rises = 0; n_first = 0; n_last = 0;
    got = '0; stable = 1; reqok = 1;
    prev_clk = clock_out;
    prev_dat = data_out;
    while (rises < 16 && n < 2000) begin
      read_finished_strobe = noise && (n == 9 || n == 37);
      read_data = read_finished_strobe ? 16'hFFFF : 16'($urandom);
      @(negedge clk);
      n++;
      if (read_request !== 1'b0) reqok = 0;
      if (clock_out === 1'b1 && prev_clk === 1'b0) begin
        got = {got[14:0], data_out};
        if (data_out !== prev_dat) stable = 0;
        if (rises == 0) n_first = n;
        n_last = n;
        rises++;
      end
      prev_clk = clock_out;
      prev_dat = data_out;
    end
    read_finished_strobe = 1'b0;
    chk("rise_count", rises, 16);
    chk("word_bits", got, d);
    chk("data_stable", stable, 1);
    chk("bit_period", n_last - n_first, 15 * 2 * HP);
    chk("no_req_in_shift", reqok, 1);
    n = 0;
    while (clock_out !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("clk_back_low", clock_out, 0);
    chk("dat_back_low", data_out, 0);
  endtask

  // One whole frame; inputs are scrambled mid-frame and set to the next
  // frame's values during the gap. Gap length measured when a next frame reads.
  task automatic run_frame(input int wc, input logic [AW-1:0] start,
                           input logic [AW-1:0] nwc, input logic [AW-1:0] nstart,
                           input bit noise, input logic [15:0] d0, input int dly0);
    int cnt;
    bit quiet;
    logic [AW-1:0] a;
    for (int i = 0; i < wc; i++) begin
      a = start + AW'(i);
      serve_word(a, (i == 0) ? dly0 : $urandom_range(0, 5),
                 (i == 0) ? d0 : 16'($urandom), noise);
      if (i == 0) begin
        word_count    = 16'($urandom);
        start_address = 16'($urandom);
      end
    end
    word_count    = nwc;
    start_address = nstart;
    if (nwc != 0) begin
      cnt = 1;
      quiet = 1;
      while (read_request !== 1'b1 && cnt < 1000) begin
        read_finished_strobe = noise && (cnt == 10);
        read_data = 16'hFFFF;
        @(negedge clk);
        read_finished_strobe = 1'b0;
        if (read_request !== 1'b1) begin
          cnt++;
          if (clock_out !== 1'b0 || data_out !== 1'b0) quiet = 0;
        end
      end
      chk("gap_len", cnt, GAP);
      chk("gap_quiet", quiet, 1);
    end
  endtask

  initial begin
    int n;
    int rises;
    bit ok;
    logic prev_clk;
    logic [AW-1:0] cur_wc, cur_st, nx_wc, nx_st;

    rst = 1'b0;
    read_finished_strobe = 1'b0;
    read_data = '0;
    word_count = 16'd1;
    start_address = 16'h0100;
    repeat (3) @(negedge clk);
    chk("rst_data", data_out, 0);
    chk("rst_clk", clock_out, 0);
    chk("rst_req", read_request, 0);
    chk("rst_addr", read_address, 0);

    // First edge after release starts a frame immediately.
    rst = 1'b1;
    @(negedge clk);
    chk("first_req", read_request, 1);
    chk("first_addr", read_address, 16'h0100);

    run_frame(1, 16'h0100, 16'd3, 16'hFFFE, 1'b0, 16'hA5C3, 3);
    run_frame(3, 16'hFFFE, 16'd3, 16'hFFFE, 1'b1, 16'($urandom), 1);
    run_frame(3, 16'hFFFE, 16'd0, 16'h0000, 1'b1, 16'($urandom), 0);

    // word_count = 0: nothing is ever fetched or clocked.
    ok = 1;
    repeat (2000) begin
      @(negedge clk);
      if (read_request !== 1'b0 || clock_out !== 1'b0) ok = 0;
    end
    chk("wc0_idle", ok, 1);

    // Reset in the middle of bit 7 of a word.
    word_count = 16'd2;
    start_address = 16'h1234;
    n = 0;
    while (read_request !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("pre_rst_req", read_address, 16'h1234);
    read_finished_strobe = 1'b1;
    read_data = 16'hFFFF;
    @(negedge clk);
    read_finished_strobe = 1'b0;
    n = 0; rises = 0;
    prev_clk = clock_out;
    while (rises < 8 && n < 500) begin
      @(negedge clk);
      n++;
      if (clock_out === 1'b1 && prev_clk === 1'b0) rises++;
      prev_clk = clock_out;
    end
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("async_data", data_out, 0);
    chk("async_clk", clock_out, 0);
    chk("async_req", read_request, 0);
    chk("async_addr", read_address, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("restart_req", read_request, 1);
    chk("restart_addr", read_address, 16'h1234);

    cur_wc = 16'd3;
    cur_st = 16'hFFFF;
    run_frame(2, 16'h1234, cur_wc, cur_st, 1'b1, 16'($urandom), 2);

    for (int k = 0; k < 5; k++) begin
      nx_wc = AW'($urandom_range(1, 4));
      nx_st = ($urandom_range(0, 1) == 1) ? AW'(16'hFFFF - 16'($urandom_range(0, 2)))
                                          : AW'($urandom);
      run_frame(int'(cur_wc), cur_st, nx_wc, nx_st, k[0], 16'($urandom),
                $urandom_range(0, 6));
      cur_wc = nx_wc;
      cur_st = nx_st;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
